// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: two-requester (A = core, B = loader) single-port data-memory |
// | arbiter with burst-limited handover. Define MEM_ARB_RR_EN for round-robin |
// | tie-break in IDLE; otherwise A wins ties.                                 |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic [7:0]    a_rdata,
  output logic [7:0]    b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [3:0] c_MAX_CNT = 4'(MAX_BURST - 1);
  localparam logic       c_SRV_A   = 1'b0;
  localparam logic       c_SRV_B   = 1'b1;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_beatCnt;
  logic [3:0] w_beatCntNext;
  logic       r_lastSrv;
  logic       w_tieToA;
  logic       w_beat;

`ifdef MEM_ARB_RR_EN
  assign w_tieToA = (r_lastSrv == c_SRV_B);
`else
  // last_srv is still tracked but has no consumer in the fixed-priority build.
  logic w_unusedLastSrv;
  assign w_unusedLastSrv = r_lastSrv;
  assign w_tieToA        = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_beatCnt <= 4'd0;
      r_lastSrv <= c_SRV_B;
    end else begin
      r_state   <= w_nextState;
      r_beatCnt <= w_beatCntNext;
      if (w_nextState != r_state) begin
        if (w_nextState == GNT_A) r_lastSrv <= c_SRV_A;
        else if (w_nextState == GNT_B) r_lastSrv <= c_SRV_B;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 8'h00;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    a_rdata     = 8'h00;
    b_rdata     = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (a_req && b_req) w_nextState = w_tieToA ? GNT_A : GNT_B;
        else if (a_req)     w_nextState = GNT_A;
        else if (b_req)     w_nextState = GNT_B;
      end
      GNT_A: begin
        a_gnt     = 1'b1;
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
        mem_we    = a_req & a_we;
        mem_re    = a_req & ~a_we;
        a_rdata   = mem_rdata;
        if (a_req) begin
          if ((r_beatCnt == c_MAX_CNT) && b_req) w_nextState = GNT_B;
        end else begin
          w_nextState = b_req ? GNT_B : IDLE;
        end
      end
      GNT_B: begin
        b_gnt     = 1'b1;
        mem_addr  = b_addr;
        mem_wdata = b_wdata;
        mem_we    = b_req & b_we;
        mem_re    = b_req & ~b_we;
        b_rdata   = mem_rdata;
        if (b_req) begin
          if ((r_beatCnt == c_MAX_CNT) && a_req) w_nextState = GNT_A;
        end else begin
          w_nextState = a_req ? GNT_A : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_beat = (a_gnt & a_req) | (b_gnt & b_req);

  // Counter stops at MAX_BURST-1 so a lone requester never wraps into a false handover.
  always_comb begin
    w_beatCntNext = r_beatCnt;
    if (w_nextState != r_state)                 w_beatCntNext = 4'd0;
    else if (w_beat && (r_beatCnt != c_MAX_CNT)) w_beatCntNext = r_beatCnt + 4'd1;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8, address width, matching the data memory depth of 2**AW.
REQ-002 Parameter MAX_BURST, default 4, max consecutive granted beats before forced handover when the other side waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_req, b_req  input  1  access request from requester A (core) / B (loader).
REQ-006 a_we, b_we  input  1  1 = write, 0 = read, valid with req.
REQ-007 a_addr, b_addr  input  AW  access address.
REQ-008 a_wdata, b_wdata  input  8  write data.
REQ-009 a_gnt, b_gnt  output  1  grant; a beat completes on each rising edge where x_req and x_gnt are both 1.
REQ-010 a_rdata, b_rdata  output  8  read data, valid in any cycle where x_gnt=1.
REQ-011 mem_addr  output  AW; mem_re  output  1; mem_we  output  1; mem_wdata  output  8  drive the data memory.
REQ-012 mem_rdata  input  8  combinational read data from the data memory.

Function
REQ-013 FSM states IDLE, GNT_A, GNT_B; a_gnt=1 only in GNT_A, b_gnt=1 only in GNT_B (Moore, from registered state).
REQ-014 IDLE: no req -> IDLE; exactly one req -> that side's GNT state next edge (1-cycle req-to-gnt latency).
REQ-015 IDLE, both req: winner chosen per REQ-027/REQ-028.
REQ-016 GNT_x with x_req=1: stay, unless beat counter = MAX_BURST-1 and other req=1 -> GNT_other at that edge.
REQ-017 GNT_x with x_req=0: other req=1 -> GNT_other; else -> IDLE; zero-gap handover, no IDLE bubble.
REQ-018 Beat counter (4 bits) increments on each completed beat, clears on any state change; saturates at MAX_BURST-1 when other side idle.
REQ-019 mem_addr/mem_wdata = granted side's addr/wdata; IDLE drives 0.
REQ-020 mem_we = x_gnt & x_req & x_we; mem_re = x_gnt & x_req & ~x_we; both 0 in IDLE.
REQ-021 Write commits in memory at the edge ending the beat; read data is combinational same cycle.
REQ-022 x_rdata = mem_rdata when x_gnt=1, else 8'h00; the non-granted side never sees the other's data.
REQ-023 Requester changing addr/we/wdata while granted is legal; each cycle is an independent beat.
REQ-024 last_srv register records the side of the most recent grant, updated on entry to GNT_A/GNT_B.

Reset
REQ-025 rst_n=0 immediately forces state IDLE, counter 0, last_srv=B, a_gnt=b_gnt=0, mem_we=mem_re=0, mem_addr=mem_wdata=0, rdata=0, without waiting for clk.
REQ-026 Reset asserted mid-burst drops the grant in the same cycle; no write is issued while rst_n=0; after release, the FSM re-arbitrates from IDLE.

Configuration
REQ-027 MEM_ARB_RR_EN defined: simultaneous request in IDLE grants the side not equal to last_srv (round-robin; A wins first after reset).
REQ-028 MEM_ARB_RR_EN undefined: simultaneous request in IDLE always grants A; last_srv is still maintained; MAX_BURST preemption (REQ-016) applies in both builds.

Verification
REQ-029 Reset, then a_req=1 we=1 addr=8'h10 wdata=8'hA5 one beat -> a_gnt 1 cycle after req, mem_we=1 for 1 cycle, later B read of 8'h10 returns 8'hA5.
REQ-030 a_req and b_req both rise in the same cycle after reset, RR build -> A granted first; both held -> after 4 A beats, B granted next cycle with no IDLE cycle; fixed build, both dropping then re-requesting -> A again.
REQ-031 A holds req 10 cycles, B idle -> a_gnt stays 1 all 10 cycles, counter saturates, no handover.
REQ-032 B granted, reading addr 8'h20 (=8'h3C) -> b_rdata=8'h3C, a_rdata=8'h00 same cycle.
REQ-033 rst_n pulled low between edges during A write burst -> a_gnt, mem_we drop to 0 before next edge; memory at the in-flight address unchanged.
REQ-034 A drops req while B waiting -> b_gnt=1 on the next edge, mem_we never asserted for A in the handover cycle.
